pc_hazard_ctrl: RTL and testbench
=================================

# pc_hazard_ctrl

Front-end sequencer for the 5-stage pipeline: owns the PC register and decides each cycle whether fetch advances, holds or redirects. It consumes the EX-stage branch/jump target from the immediate/PC-adder path and the ID/EX register-dependency information. It then drives the stage-register stall/flush controls for load-use hazards, taken control transfers and external memory waits. A misaligned control-transfer target halts the pipeline and latches an error until reset.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `CNT_W`, 16, width of the saturating stall/flush event counters
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall_ext`  in  1  global freeze request (instruction/data memory wait)
- `id_rs1`, `id_rs2`  in  5 each  source registers of instruction in ID
- `id_re1`, `id_re2`  in  1 each  source register actually read
- `ex_valid`  in  1  EX holds a real instruction (not a bubble)
- `ex_is_load`  in  1  EX instruction is a load
- `ex_rd`  in  5  EX destination register
- `ex_npc_op`  in  2  EX control-transfer kind (package encoding)
- `ex_br_taken`  in  1  branch comparison result for EX instruction
- `ex_pc_imm`  in  32  EX pc + sign-extended immediate (BR/JAL target)
- `ex_alu_c`  in  32  EX ALU result (JALR base + offset)
- `pc`  out  32  registered fetch address
- `pc_plus4`  out  32  `pc + 4`, combinational
- `pipe_hold`  out  1  freeze every stage register
- `if_id_stall`  out  1  hold IF/ID register
- `if_id_flush`  out  1  clear IF/ID to bubble
- `id_ex_flush`  out  1  load bubble into ID/EX
- `misalign_err`  out  1  sticky error flag
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters

## Operation
- FSM states: RUN, HALT. Reset -> RUN.
- Redirect condition `redir` = `ex_valid` and (`ex_npc_op`==NPC_JAL, or NPC_JALR, or NPC_BR with `ex_br_taken`).
- Target: BR/JAL -> `ex_pc_imm`; JALR -> `{ex_alu_c[31:1],1'b0}`.
- Load-use `lu` = `ex_valid` and `ex_is_load` and `ex_rd`!=0 and ((`id_re1` and `id_rs1`==`ex_rd`) or (`id_re2` and `id_rs2`==`ex_rd`)).
- Priority per cycle in RUN: `stall_ext` > misaligned redirect > `redir` > `lu` > normal.
  - `stall_ext`: `pipe_hold`=1, pc held, no flushes, counters unchanged. A pending redirect is re-evaluated next cycle, because EX is frozen.
  - `redir` with target[1:0]!=0: go to HALT. Pc is held, `if_id_flush`=`id_ex_flush`=1, and `misalign_err` is set next edge.
  - `redir`: pc <= target, `if_id_flush`=`id_ex_flush`=1. `flush_cnt`+1. `lu` in the same cycle is ignored.
  - `lu`: pc held, `if_id_stall`=1, `id_ex_flush`=1. `stall_cnt`+1.
  - normal: pc <= pc+4.
- HALT: pc held. `pipe_hold`=0, `if_id_flush`=`id_ex_flush`=1 every cycle, so the pipeline drains. `misalign_err`=1. Only reset leaves HALT.
- Counters saturate at all-ones and do not wrap.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 -> 0.

## Timing
- Reset values: `pc`=RESET_PC, `misalign_err`=0, `stall_cnt`=`flush_cnt`=0, state RUN. All combinational outputs deassert under reset.
- Stall/flush outputs are combinational from the current inputs and state, and take effect at the same edge.
- Redirect penalty is 2 cycles: the IF and ID instructions are squashed. The target is fetched the cycle after `redir`.
- Load-use penalty is 1 cycle. The next cycle, the load is in MEM and `lu` deasserts without any held state.
- Reset asserted mid-stall or in HALT returns to RESET_PC and RUN immediately (asynchronous).

## Structure
- Shared package `pipe_ctrl_pkg`: NPC_PC4=2'b00, NPC_BR=2'b01, NPC_JAL=2'b10, NPC_JALR=2'b11; state enum RUN/HALT; RESET_PC default.
- One natural sub-module: `sat_counter` (parameterised width, `inc` and `clr`), instantiated twice.

## Test plan
- Reset release with no hazards -> pc 0, 4, 8, 12 on successive edges; all stall/flush outputs 0.
- EX `lw x5`, ID `add x6,x5,x1` (`id_re1`=1, `id_rs1`=5) -> one cycle with `if_id_stall`=1, `id_ex_flush`=1, pc held; `stall_cnt`=1. Same case with `ex_rd`=0 -> no stall.
- NPC_BR taken, `ex_pc_imm`=0x100, together with a load-use -> both flushes=1, pc=0x100 next edge, `stall_cnt` unchanged, `flush_cnt`=1.
- NPC_JALR with `ex_alu_c`=0x203 -> target 0x202 misaligned: HALT, `misalign_err`=1, pc frozen, flushes held high; `rst_n` pulse -> pc=RESET_PC, flag cleared.
- `stall_ext`=1 for 3 cycles while NPC_JAL is in EX -> pc frozen, no flush. On release, pc=`ex_pc_imm` next edge.
- With CNT_W=2, force 5 load-use stalls -> `stall_cnt` sticks at 3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the front-end sequencer:
// next-PC kinds, sequencer state and reset PC.
package pipe_ctrl_pkg;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_JALR = 2'b11;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that stops at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_hazard_ctrl.sv
// PC register plus stall/flush sequencing for
// load-use, control transfers and memory waits.
module pc_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_ext,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [1:0]       ex_npc_op,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_pc_imm,
  input  logic [31:0]      ex_alu_c,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             pipe_hold,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;

  logic        redir, lu, mis;
  logic [31:0] target;
  logic        hold_c, stall_c, iff_c, ief_c;
  logic        stall_inc, flush_inc;

  assign redir = ex_valid &&
    ((ex_npc_op == NPC_JAL) ||
     (ex_npc_op == NPC_JALR) ||
     ((ex_npc_op == NPC_BR) && ex_br_taken));

  assign target = (ex_npc_op == NPC_JALR)
    ? (ex_alu_c & ~32'h1) : ex_pc_imm;

  assign mis = redir && (target[1:0] != 2'b00);

  assign lu = ex_valid && ex_is_load &&
    (ex_rd != 5'd0) &&
    ((id_re1 && (id_rs1 == ex_rd)) ||
     (id_re2 && (id_rs2 == ex_rd)));

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_d     = err_q;
    hold_c    = 1'b0;
    stall_c   = 1'b0;
    iff_c     = 1'b0;
    ief_c     = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (state_q == HALT) begin
      iff_c = 1'b1;
      ief_c = 1'b1;
    end else if (stall_ext) begin
      hold_c = 1'b1;
    end else if (mis) begin
      state_d = HALT;
      err_d   = 1'b1;
      iff_c   = 1'b1;
      ief_c   = 1'b1;
    end else if (redir) begin
      pc_d      = target;
      iff_c     = 1'b1;
      ief_c     = 1'b1;
      flush_inc = 1'b1;
    end else if (lu) begin
      stall_c   = 1'b1;
      ief_c     = 1'b1;
      stall_inc = 1'b1;
    end else begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // Controls are forced low while reset is held
  assign pipe_hold    = rst_n && hold_c;
  assign if_id_stall  = rst_n && stall_c;
  assign if_id_flush  = rst_n && iff_c;
  assign id_ex_flush  = rst_n && ief_c;
  assign pc           = pc_q;
  assign misalign_err = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stall_inc),
    .clr_i (1'b0),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_inc),
    .clr_i (1'b0),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Directed bench for pc_hazard_ctrl, plus a
// 2-bit-counter instance for saturation.
module tb_pc_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_ext;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_re1, id_re2;
  logic        ex_valid, ex_is_load, ex_br_taken;
  logic [1:0]  ex_npc_op;
  logic [31:0] ex_pc_imm, ex_alu_c;

  logic [31:0] pc, pc_plus4;
  logic        pipe_hold, if_id_stall;
  logic        if_id_flush, id_ex_flush;
  logic        misalign_err;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] s_pc, s_pc4;
  logic        s_hold, s_stall, s_iff, s_ief, s_err;
  logic [1:0]  s_scnt, s_fcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_hazard_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_ext(stall_ext),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_re1(id_re1), .id_re2(id_re2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_npc_op(ex_npc_op),
    .ex_br_taken(ex_br_taken), .ex_pc_imm(ex_pc_imm),
    .ex_alu_c(ex_alu_c), .pc(pc), .pc_plus4(pc_plus4),
    .pipe_hold(pipe_hold), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .misalign_err(misalign_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pc_hazard_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .stall_ext(stall_ext),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_re1(id_re1), .id_re2(id_re2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_npc_op(ex_npc_op),
    .ex_br_taken(ex_br_taken), .ex_pc_imm(ex_pc_imm),
    .ex_alu_c(ex_alu_c), .pc(s_pc), .pc_plus4(s_pc4),
    .pipe_hold(s_hold), .if_id_stall(s_stall),
    .if_id_flush(s_iff), .id_ex_flush(s_ief),
    .misalign_err(s_err),
    .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
  );

  task automatic clear_in();
    stall_ext   = 1'b0;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_re1      = 1'b0;
    id_re2      = 1'b0;
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_rd       = 5'd0;
    ex_npc_op   = 2'b00;
    ex_br_taken = 1'b0;
    ex_pc_imm   = 32'h0;
    ex_alu_c    = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 1'b0;
    clear_in();
    #12;
    checks++;
    if (pc !== 32'h0 || misalign_err !== 1'b0 ||
        stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state pc=%h err=%b sc=%0d fc=%0d want 0",
               pc, misalign_err, stall_cnt, flush_cnt);
    end
    checks++;
    if ({pipe_hold, if_id_stall, if_id_flush, id_ex_flush} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0000",
        {pipe_hold, if_id_stall, if_id_flush, id_ex_flush});
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (pc_plus4 !== 32'd4) begin
      errors++;
      $display("FAIL reset_pc4 got %h want 4", pc_plus4);
    end
    exp = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = exp + 32'd4;
      checks++;
      if (pc !== exp ||
          {pipe_hold, if_id_stall, if_id_flush, id_ex_flush} !== 4'b0) begin
        errors++;
        $display("FAIL seq_fetch pc=%h ctl=%b want pc=%h ctl=0000", pc,
          {pipe_hold, if_id_stall, if_id_flush, id_ex_flush}, exp);
      end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] p;
    p = pc;
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = 5'd5;
    id_re1     = 1'b1;
    id_rs1     = 5'd5;
    id_re2     = 1'b1;
    id_rs2     = 5'd1;
    #1;
    checks++;
    if (if_id_stall !== 1'b1 || id_ex_flush !== 1'b1 ||
        if_id_flush !== 1'b0 || pipe_hold !== 1'b0) begin
      errors++;
      $display("FAIL lu_ctl stall=%b ief=%b iff=%b hold=%b want 1100",
        if_id_stall, id_ex_flush, if_id_flush, pipe_hold);
    end
    tick();
    checks++;
    if (pc !== p || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_hold pc=%h sc=%0d want pc=%h sc=1",
               pc, stall_cnt, p);
    end
    ex_rd  = 5'd0;
    id_rs1 = 5'd0;
    #1;
    checks++;
    if (if_id_stall !== 1'b0 || id_ex_flush !== 1'b0) begin
      errors++;
      $display("FAIL lu_x0 stall=%b ief=%b want 0 0",
               if_id_stall, id_ex_flush);
    end
    tick();
    checks++;
    if (pc !== p + 32'd4 || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_x0_adv pc=%h sc=%0d want pc=%h sc=1",
               pc, stall_cnt, p + 32'd4);
    end
    clear_in();
  endtask

  task automatic test_redir_over_lu();
    ex_valid    = 1'b1;
    ex_is_load  = 1'b1;
    ex_rd       = 5'd7;
    id_re2      = 1'b1;
    id_rs2      = 5'd7;
    ex_npc_op   = 2'b01;
    ex_br_taken = 1'b1;
    ex_pc_imm   = 32'h100;
    #1;
    checks++;
    if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1 ||
        if_id_stall !== 1'b0) begin
      errors++;
      $display("FAIL br_ctl iff=%b ief=%b stall=%b want 1 1 0",
               if_id_flush, id_ex_flush, if_id_stall);
    end
    tick();
    checks++;
    if (pc !== 32'h100 || stall_cnt !== 16'd1 ||
        flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL br_target pc=%h sc=%0d fc=%0d want 100 1 1",
               pc, stall_cnt, flush_cnt);
    end
    clear_in();
    ex_valid  = 1'b1;
    ex_npc_op = 2'b01;
    ex_pc_imm = 32'h400;
    #1;
    checks++;
    if (if_id_flush !== 1'b0) begin
      errors++;
      $display("FAIL br_not_taken iff=%b want 0", if_id_flush);
    end
    tick();
    checks++;
    if (pc !== 32'h104) begin
      errors++;
      $display("FAIL br_nt_pc pc=%h want 104", pc);
    end
    clear_in();
  endtask

  task automatic test_stall_ext();
    logic [31:0] p;
    p = pc;
    ex_valid  = 1'b1;
    ex_npc_op = 2'b10;
    ex_pc_imm = 32'h40;
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pipe_hold !== 1'b1 || if_id_flush !== 1'b0 ||
          id_ex_flush !== 1'b0) begin
        errors++;
        $display("FAIL ext_ctl hold=%b iff=%b ief=%b want 1 0 0",
                 pipe_hold, if_id_flush, id_ex_flush);
      end
      tick();
      checks++;
      if (pc !== p || flush_cnt !== 16'd1) begin
        errors++;
        $display("FAIL ext_hold pc=%h fc=%0d want %h 1",
                 pc, flush_cnt, p);
      end
    end
    stall_ext = 1'b0;
    #1;
    checks++;
    if (if_id_flush !== 1'b1 || pipe_hold !== 1'b0) begin
      errors++;
      $display("FAIL ext_release iff=%b hold=%b want 1 0",
               if_id_flush, pipe_hold);
    end
    tick();
    checks++;
    if (pc !== 32'h40 || flush_cnt !== 16'd2) begin
      errors++;
      $display("FAIL ext_jal pc=%h fc=%0d want 40 2", pc, flush_cnt);
    end
    clear_in();
  endtask

  task automatic test_pc_wrap();
    ex_valid  = 1'b1;
    ex_npc_op = 2'b11;
    ex_alu_c  = 32'hFFFF_FFFD;
    tick();
    clear_in();
    #1;
    checks++;
    if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0 ||
        flush_cnt !== 16'd3) begin
      errors++;
      $display("FAIL wrap_pc pc=%h pc4=%h fc=%0d want fffffffc 0 3",
               pc, pc_plus4, flush_cnt);
    end
    tick();
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next pc=%h want 0", pc);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] p;
    p = pc;
    ex_valid  = 1'b1;
    ex_npc_op = 2'b11;
    ex_alu_c  = 32'h203;
    #1;
    checks++;
    if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1 ||
        misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL mis_ctl iff=%b ief=%b err=%b want 1 1 0",
               if_id_flush, id_ex_flush, misalign_err);
    end
    tick();
    checks++;
    if (misalign_err !== 1'b1 || pc !== p || flush_cnt !== 16'd3) begin
      errors++;
      $display("FAIL mis_latch err=%b pc=%h fc=%0d want 1 %h 3",
               misalign_err, pc, flush_cnt, p);
    end
    clear_in();
    stall_ext = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1 ||
          pipe_hold !== 1'b0) begin
        errors++;
        $display("FAIL halt_ctl iff=%b ief=%b hold=%b want 1 1 0",
                 if_id_flush, id_ex_flush, pipe_hold);
      end
      tick();
      checks++;
      if (pc !== p || misalign_err !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold pc=%h err=%b want %h 1",
                 pc, misalign_err, p);
      end
    end
    clear_in();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || misalign_err !== 1'b0 ||
        if_id_flush !== 1'b0 || id_ex_flush !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset pc=%h err=%b iff=%b ief=%b want 0 0 0 0",
               pc, misalign_err, if_id_flush, id_ex_flush);
    end
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h4 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_reset pc=%h sc=%0d want 4 0", pc, stall_cnt);
    end
  endtask

  task automatic test_saturate();
    int exp_s;
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = 5'd9;
    id_re2     = 1'b1;
    id_rs2     = 5'd9;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp_s = (i > 3) ? 3 : i;
      checks++;
      if (s_scnt !== 2'(exp_s) || stall_cnt !== 16'(i)) begin
        errors++;
        $display("FAIL sat_cnt n=%0d narrow=%0d wide=%0d want %0d %0d",
                 i, s_scnt, stall_cnt, exp_s, i);
      end
    end
    checks++;
    if (pc !== 32'h4) begin
      errors++;
      $display("FAIL sat_pc pc=%h want 4", pc);
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redir_over_lu();
    test_stall_ext();
    test_pc_wrap();
    test_misalign();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
